// File: rtl/log_pkg.sv
// Shared log RAM geometry and log_dump FSM encoding.
// The log capture block uses the same geometry constants.
package log_pkg;

  localparam int unsigned LOG_DEPTH          = 32768;
  localparam int unsigned LOG_ADDR_W         = 15;
  localparam int unsigned LOG_DATA_W         = 32;
  localparam int unsigned LOG_BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StLatch,
    StSend,
    StNext,
    StCsum
  } log_dump_state_e;

endpackage

// File: rtl/mod_m_counter.sv
// Modulo-M counter with synchronous clear, count enable and terminal-count flag.
module mod_m_counter #(
  parameter int unsigned M = 8,
  parameter int unsigned W = $clog2(M)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         run,
  output logic [W-1:0] count,
  output logic         max
);

  localparam logic [W-1:0] Last = W'(M - 1);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (run) begin
      count_d = (count_q == Last) ? '0 : count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign max   = (count_q == Last);

endmodule

// File: rtl/log_dump.sv
// Drains the log RAM (addresses 0..DEPTH-1) as an MSB-first byte stream over valid/ready.
// Define LOG_DUMP_CHECKSUM_EN to append a running XOR checksum byte after the last word.
module log_dump
  import log_pkg::*;
#(
  parameter int unsigned DEPTH  = LOG_DEPTH,
  parameter int unsigned ADDR_W = LOG_ADDR_W,
  parameter int unsigned DATA_W = LOG_DATA_W
) (
  input  logic              clockdsp,
  input  logic              soft_reset,
  input  logic              dump_start,
  input  logic              log_full,
  output logic [ADDR_W-1:0] ram_read_addr,
  input  logic [DATA_W-1:0] ram_read_data,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              dump_busy,
  output logic              dump_done,
  output logic              dump_err
);

  localparam int unsigned Bytes = DATA_W / 8;
  localparam int unsigned CntW  = (Bytes > 1) ? $clog2(Bytes) : 1;
  localparam logic [CntW-1:0] LastByte = CntW'(Bytes - 1);

  log_dump_state_e   state_q, state_d;
  logic              start_q, start_d;
  logic              full_q, full_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CntW-1:0]   byte_q, byte_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
`ifdef LOG_DUMP_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  logic accept;
  logic xfer;
  logic at_max;
  logic cnt_rst;
  logic cnt_run;

  // Start and log_full are registered together so the error flag reflects
  // log_full at the moment the request was made.
  assign accept  = (state_q == StIdle) && start_q;
  assign xfer    = tx_valid && tx_ready;
  assign cnt_rst = soft_reset || accept;
  assign cnt_run = (state_q == StNext) && !at_max;

  mod_m_counter #(
    .M (DEPTH),
    .W (ADDR_W)
  ) u_addr_cnt (
    .clk   (clockdsp),
    .rst   (cnt_rst),
    .run   (cnt_run),
    .count (ram_read_addr),
    .max   (at_max)
  );

  always_comb begin
    state_d  = state_q;
    start_d  = dump_start && (state_q == StIdle) && !start_q;
    full_d   = log_full;
    shift_d  = shift_q;
    byte_d   = byte_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = err_q;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
`ifdef LOG_DUMP_CHECKSUM_EN
    csum_d   = csum_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StRead;
          busy_d  = 1'b1;
          err_d   = !full_q;
          byte_d  = '0;
`ifdef LOG_DUMP_CHECKSUM_EN
          csum_d  = 8'h00;
`endif
        end
      end
      StRead: begin
        state_d = StLatch;
      end
      StLatch: begin
        shift_d = ram_read_data;
        byte_d  = '0;
        state_d = StSend;
      end
      StSend: begin
        tx_valid = 1'b1;
        tx_data  = shift_q[DATA_W-1 -: 8];
        if (xfer) begin
          shift_d = shift_q << 8;
`ifdef LOG_DUMP_CHECKSUM_EN
          csum_d  = csum_q ^ tx_data;
`endif
          if (byte_q == LastByte) begin
            state_d = StNext;
          end else begin
            byte_d = byte_q + CntW'(1);
          end
        end
      end
      StNext: begin
        if (at_max) begin
`ifdef LOG_DUMP_CHECKSUM_EN
          state_d = StCsum;
`else
          state_d = StIdle;
          busy_d  = 1'b0;
          done_d  = 1'b1;
`endif
        end else begin
          state_d = StRead;
        end
      end
`ifdef LOG_DUMP_CHECKSUM_EN
      StCsum: begin
        tx_valid = 1'b1;
        tx_data  = csum_q;
        if (xfer) begin
          state_d = StIdle;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
`endif
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clockdsp) begin
    if (soft_reset) begin
      state_q <= StIdle;
      start_q <= 1'b0;
      full_q  <= 1'b0;
      shift_q <= '0;
      byte_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef LOG_DUMP_CHECKSUM_EN
      csum_q  <= 8'h00;
`endif
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      full_q  <= full_d;
      shift_q <= shift_d;
      byte_q  <= byte_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef LOG_DUMP_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign dump_busy = busy_q;
  assign dump_done = done_q;
  assign dump_err  = err_q;

endmodule
